// File: rtl/oled_pkg.sv
// Shared definitions for the OLED display path: line-fetch FSM states,
// address field widths and the DC levels used by the SPI serializer.
package oled_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   localparam int BYTES_PER_LINE_DEF = 192;
   localparam int LINE_BITS          = 8 * BYTES_PER_LINE_DEF;

   // Pixel memory byte address is {img, line, byte}
   localparam int LINE_FLD_W = 6;
   localparam int BYTE_FLD_W = 8;

   // DC pin level seen by the panel: low for commands, high for pixel data
   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   function automatic int line_bits(input int bytes_per_line);
      return 8 * bytes_per_line;
   endfunction

endpackage

// File: rtl/oled_rd_pipe.sv
// Valid shift pipe matching the pixel memory read latency, so a capture
// strobe arrives in the same cycle as the byte it belongs to.
module oled_rd_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic CLK,
   input  logic rst,
   input  logic in_vld,
   output logic out_vld
);

   logic [RD_LAT-1:0] pipe_q;
   logic [RD_LAT-1:0] pipe_d;

   // Shift the read-issue flag one stage per cycle
   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = in_vld;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Pipe register, emptied on reset so no stale strobe survives an abort
   always_ff @(posedge CLK) begin
      if (!rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign out_vld = pipe_q[RD_LAT-1];

endmodule

// File: rtl/oled_line_fetch.sv
// Reads one image line by line from byte-wide pixel memory, packs each line
// into one wide word (first byte in the MSBs) and offers it to the SPI
// serializer over valid/ready. The next line is fetched while the current
// one waits in the output slot.
module oled_line_fetch
   import oled_pkg::*;
#(
   parameter int BYTES_PER_LINE = 192,
   parameter int LINES          = 64,
   parameter int IMG_W          = 4,
   parameter int RD_LAT         = 1
) (
   input  logic                                      CLK,
   input  logic                                      rst,
   input  logic [IMG_W-1:0]                          current,
   input  logic                                      frame_start,
   output logic                                      mem_en,
   output logic [IMG_W+LINE_FLD_W+BYTE_FLD_W-1:0]    mem_addr,
   input  logic [7:0]                                mem_dout,
   output logic [8*BYTES_PER_LINE-1:0]               line_data,
   output logic [LINE_FLD_W-1:0]                     line_idx,
   output logic                                      line_valid,
   input  logic                                      line_ready,
   output logic                                      busy,
   output logic                                      frame_done
);

   localparam int LB    = line_bits(BYTES_PER_LINE);
   localparam int CNT_W = $clog2(BYTES_PER_LINE + 1);

   localparam logic [CNT_W-1:0]      BPL_CNT   = CNT_W'(BYTES_PER_LINE);
   localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BYTES_PER_LINE - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [LINE_FLD_W-1:0] LAST_LINE = LINE_FLD_W'(LINES - 1);
   localparam logic [LINE_FLD_W-1:0] LINE_ONE  = LINE_FLD_W'(1);

   state_e                 state_q, state_d;
   logic [IMG_W-1:0]       img_q, img_d;
   logic [LINE_FLD_W-1:0]  line_q, line_d;
   logic [CNT_W-1:0]       issue_q, issue_d;
   logic [CNT_W-1:0]       cap_q, cap_d;
   logic [LB-1:0]          asm_q, asm_d;
   logic [LB-1:0]          line_data_q, line_data_d;
   logic [LINE_FLD_W-1:0]  line_idx_q, line_idx_d;
   logic                   line_valid_q, line_valid_d;
   logic                   busy_q, busy_d;
   logic                   frame_done_q, frame_done_d;

   logic                   cap_vld;
   logic                   accept;

   oled_rd_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .CLK     (CLK),
      .rst     (rst),
      .in_vld  (mem_en),
      .out_vld (cap_vld)
   );

   assign accept = line_valid_q & line_ready;

   // Next-state logic: read issue, byte capture and output-slot handoff
   always_comb begin
      state_d      = state_q;
      img_d        = img_q;
      line_d       = line_q;
      issue_d      = issue_q;
      cap_d        = cap_q;
      asm_d        = asm_q;
      line_data_d  = line_data_q;
      line_idx_d   = line_idx_q;
      line_valid_d = line_valid_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      mem_en       = 1'b0;

      // A transfer empties the slot unless HOLD refills it below
      if (accept) begin
         line_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               img_d   = current;
               line_d  = '0;
               issue_d = '0;
               cap_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (issue_q < BPL_CNT) begin
               mem_en  = 1'b1;
               issue_d = issue_q + CNT_ONE;
            end
            if (cap_vld) begin
               asm_d = {asm_q[LB-9:0], mem_dout};
               cap_d = cap_q + CNT_ONE;
               if (cap_q == LAST_CNT) begin
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (!line_valid_q || line_ready) begin
               line_data_d  = asm_q;
               line_idx_d   = line_q;
               line_valid_d = 1'b1;
               if (line_q == LAST_LINE) begin
                  state_d = ST_DRAIN;
               end else begin
                  line_d  = line_q + LINE_ONE;
                  issue_d = '0;
                  cap_d   = '0;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_DRAIN: begin
            if (accept) begin
               frame_done_d = 1'b1;
               busy_d       = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame in progress
   always_ff @(posedge CLK) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         img_q        <= '0;
         line_q       <= '0;
         issue_q      <= '0;
         cap_q        <= '0;
         asm_q        <= '0;
         line_data_q  <= '0;
         line_idx_q   <= '0;
         line_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         img_q        <= img_d;
         line_q       <= line_d;
         issue_q      <= issue_d;
         cap_q        <= cap_d;
         asm_q        <= asm_d;
         line_data_q  <= line_data_d;
         line_idx_q   <= line_idx_d;
         line_valid_q <= line_valid_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Address is forced to zero whenever no read is issued
   assign mem_addr   = mem_en ? {img_q, line_q, BYTE_FLD_W'(issue_q)} : '0;
   assign line_data  = line_data_q;
   assign line_idx   = line_idx_q;
   assign line_valid = line_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_oled_line_fetch.sv
// Bench for oled_line_fetch: one RD_LAT=1 instance under full check and an
// RD_LAT=2 instance on the same stimulus for latency and byte order.
module tb_oled_line_fetch;

   localparam int BPL   = 192;
   localparam int LINES = 64;
   localparam int IMG_W = 4;
   localparam int LB    = 8 * BPL;
   localparam int AW    = IMG_W + 14;

   logic             CLK = 1'b0;
   logic             rst;
   logic [IMG_W-1:0] current;
   logic             frame_start;
   logic             line_ready;

   logic             mem_en, mem_en2;
   logic [AW-1:0]    mem_addr, mem_addr2;
   logic [7:0]       mem_dout, mem_dout2;
   logic [LB-1:0]    line_data, line_data2;
   logic [5:0]       line_idx, line_idx2;
   logic             line_valid, line_valid2;
   logic             busy, busy2;
   logic             frame_done, frame_done2;

   always #5 CLK = ~CLK;

   oled_line_fetch #(.BYTES_PER_LINE(BPL), .LINES(LINES), .IMG_W(IMG_W), .RD_LAT(1)) dut (
      .CLK(CLK), .rst(rst), .current(current), .frame_start(frame_start),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .line_data(line_data), .line_idx(line_idx), .line_valid(line_valid),
      .line_ready(line_ready), .busy(busy), .frame_done(frame_done));

   oled_line_fetch #(.BYTES_PER_LINE(BPL), .LINES(LINES), .IMG_W(IMG_W), .RD_LAT(2)) dut2 (
      .CLK(CLK), .rst(rst), .current(current), .frame_start(frame_start),
      .mem_en(mem_en2), .mem_addr(mem_addr2), .mem_dout(mem_dout2),
      .line_data(line_data2), .line_idx(line_idx2), .line_valid(line_valid2),
      .line_ready(line_ready), .busy(busy2), .frame_done(frame_done2));

   // Pixel memory contents: low address byte XOR line number
   function automatic logic [7:0] mem_fn(input logic [AW-1:0] a);
      return a[7:0] ^ {2'b00, a[13:8]};
   endfunction

   logic [7:0] rd1_q = 8'h00, rd2a_q = 8'h00, rd2b_q = 8'h00;
   always @(posedge CLK) if (mem_en) rd1_q <= mem_fn(mem_addr);
   always @(posedge CLK) begin
      if (mem_en2) rd2a_q <= mem_fn(mem_addr2);
      rd2b_q <= rd2a_q;
   end
   assign mem_dout  = rd1_q;
   assign mem_dout2 = rd2b_q;

   // Expected line word: byte b of line l sits at bits [LB-1-8b -: 8]
   function automatic logic [LB-1:0] exp_line(input int l);
      logic [LB-1:0] v;
      v = '0;
      for (int b = 0; b < BPL; b++) v[LB-1-8*b -: 8] = 8'(b) ^ 8'(l);
      return v;
   endfunction

   typedef struct {
      logic [5:0]    idx;
      logic [LB-1:0] data;
   } sb_t;
   sb_t exp_q[$];

   typedef struct {
      int            cyc;
      logic          men;
      logic [AW-1:0] addr;
      logic          lv;
      logic          bsy;
      logic          lv2;
   } vec_t;
   vec_t tbl[9];

   int n_tests = 0, n_fail = 0;
   int cyc = 0, last_acc = -10, fd_cnt = 0, n_acc = 0;
   logic [IMG_W-1:0] mon_img = '0;
   logic [5:0]       mon_line = '0;
   logic [7:0]       mon_byte = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_line(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      int bad;
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         bad = 0;
         for (int b = BPL - 1; b >= 0; b--) if (act[LB-1-8*b -: 8] !== exp[LB-1-8*b -: 8]) bad = b;
         $display("FAIL %s: byte %0d got %0h want %0h (cycle %0d)", nm, bad,
                  act[LB-1-8*bad -: 8], exp[LB-1-8*bad -: 8], cyc);
      end
   endtask

   // Per-cycle checks at the falling edge: address sequence, scoreboard, frame_done
   task automatic monitor();
      sb_t e;
      if (rst) begin
         if (mem_en) begin
            chk("mem_addr_seq", 64'(mem_addr), 64'({mon_img, mon_line, mon_byte}));
            if (mon_byte == 8'(BPL - 1)) begin
               mon_byte = '0;
               mon_line = mon_line + 6'd1;
            end else begin
               mon_byte = mon_byte + 8'd1;
            end
         end
         if (line_valid && line_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_underflow: got line %0d want none (cycle %0d)", line_idx, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("line_idx", 64'(line_idx), 64'(e.idx));
               chk_line("line_data", line_data, e.data);
            end
            if (line_idx == 6'd63) last_acc = cyc;
         end
         if (frame_done) begin
            fd_cnt++;
            chk("frame_done_cyc", 64'(cyc), 64'(last_acc + 1));
            chk("busy_at_done", 64'(busy), 64'd0);
         end
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      monitor();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic check_idle(input string nm);
      chk({nm, "_mem_en"}, 64'(mem_en), 64'd0);
      chk({nm, "_mem_addr"}, 64'(mem_addr), 64'd0);
      chk({nm, "_line_valid"}, 64'(line_valid), 64'd0);
      chk({nm, "_line_idx"}, 64'(line_idx), 64'd0);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_frame_done"}, 64'(frame_done), 64'd0);
      chk_line({nm, "_line_data"}, line_data, '0);
      chk({nm, "_dut2_ctl"}, 64'({mem_en2, line_valid2, busy2, frame_done2}), 64'd0);
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      exp_q.delete();
      check_idle("reset");
   endtask

   task automatic start_frame(input logic [IMG_W-1:0] img);
      current     = img;
      frame_start = 1'b1;
      mon_img     = img;
      mon_line    = '0;
      mon_byte    = '0;
      for (int l = 0; l < LINES; l++) exp_q.push_back('{idx: 6'(l), data: exp_line(l)});
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_frame_done(input int budget, input string nm);
      int base;
      int k;
      base = fd_cnt;
      k = 0;
      while (fd_cnt == base && k < budget) begin
         tick();
         k++;
      end
      chk({nm, "_done_seen"}, 64'(fd_cnt - base), 64'd1);
      repeat (50) tick();
      chk({nm, "_done_once"}, 64'(fd_cnt - base), 64'd1);
      chk({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
      chk({nm, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int c;
      int k;
      int base;

      tbl[0] = '{1,   1'b1, {4'h3, 6'd0, 8'd0},   1'b0, 1'b1, 1'b0};
      tbl[1] = '{2,   1'b1, {4'h3, 6'd0, 8'd1},   1'b0, 1'b1, 1'b0};
      tbl[2] = '{100, 1'b1, {4'h3, 6'd0, 8'd99},  1'b0, 1'b1, 1'b0};
      tbl[3] = '{192, 1'b1, {4'h3, 6'd0, 8'd191}, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{193, 1'b0, 18'd0,                1'b0, 1'b1, 1'b0};
      tbl[5] = '{194, 1'b0, 18'd0,                1'b0, 1'b1, 1'b0};
      tbl[6] = '{195, 1'b1, {4'h3, 6'd1, 8'd0},   1'b1, 1'b1, 1'b0};
      tbl[7] = '{196, 1'b1, {4'h3, 6'd1, 8'd1},   1'b0, 1'b1, 1'b1};
      tbl[8] = '{197, 1'b1, {4'h3, 6'd1, 8'd2},   1'b0, 1'b1, 1'b0};

      rst         = 1'b0;
      current     = '0;
      frame_start = 1'b0;
      line_ready  = 1'b0;
      tick();
      tick();
      check_idle("rst_low");
      rst = 1'b1;
      tick();
      check_idle("rst_rel");

      // First line latency and address pattern, ready tied high
      line_ready = 1'b1;
      start_frame(4'h3);
      c = 1;
      for (int i = 0; i < 9; i++) begin
         while (c < tbl[i].cyc) begin
            tick();
            c++;
         end
         chk($sformatf("c%0d_mem_en", c), 64'(mem_en), 64'(tbl[i].men));
         chk($sformatf("c%0d_mem_addr", c), 64'(mem_addr), 64'(tbl[i].addr));
         chk($sformatf("c%0d_line_valid", c), 64'(line_valid), 64'(tbl[i].lv));
         chk($sformatf("c%0d_busy", c), 64'(busy), 64'(tbl[i].bsy));
         chk($sformatf("c%0d_lat2_valid", c), 64'(line_valid2), 64'(tbl[i].lv2));
         if (tbl[i].cyc == 196) begin
            chk("lat2_line_idx", 64'(line_idx2), 64'd0);
            chk_line("lat2_line_data", line_data2, exp_line(0));
         end
      end

      // Restart attempt with a different image mid-frame must be ignored
      repeat (800) tick();
      current     = 4'h9;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      wait_frame_done(13000, "full");

      // Back-pressure: serializer stalls for 500 cycles after the first line
      reset_dut();
      line_ready = 1'b0;
      start_frame(4'h3);
      k = 0;
      while (!line_valid && k < 400) begin
         tick();
         k++;
      end
      chk("stall_first_valid", 64'(line_valid), 64'd1);
      for (int i = 0; i < 500; i++) begin
         tick();
         chk("stall_idx", 64'(line_idx), 64'd0);
         chk_line("stall_data", line_data, exp_line(0));
      end
      chk("stall_mem_en", 64'(mem_en), 64'd0);
      chk("stall_valid", 64'(line_valid), 64'd1);
      chk("stall_busy", 64'(busy), 64'd1);
      line_ready = 1'b1;
      tick();
      chk("nogap_valid", 64'(line_valid), 64'd1);
      chk("nogap_idx", 64'(line_idx), 64'd1);
      wait_frame_done(13000, "stall");

      // Reset during the fetch of line 10 aborts without frame_done
      reset_dut();
      line_ready = 1'b1;
      start_frame(4'h3);
      k = 0;
      while (!(mon_line == 6'd10 && mon_byte == 8'd50) && k < 3000) begin
         tick();
         k++;
      end
      chk("abort_reached_line10", 64'(mon_line), 64'd10);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check_idle("abort");
      exp_q.delete();
      base = fd_cnt;
      repeat (300) tick();
      chk("abort_no_done", 64'(fd_cnt - base), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      start_frame(4'h3);
      base = n_acc;
      k = 0;
      while (n_acc < base + 2 && k < 600) begin
         tick();
         k++;
      end
      chk("restart_two_lines", 64'(n_acc - base), 64'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
